dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//  Two-requester arbiter sharing the single-port data memory (combinational read,
//  write on posedge Clk). Port 0 is the core load/store unit; port 1 is the
//  loader/debug port. One access per cycle, round-robin with a bounded burst
//  hold, read data returned registered one cycle after grant.
// PARAMETERS
//  W          8   data width (matches data memory)
//  A          8   address width (memory depth 2**A)
//  MAX_BURST  4   max consecutive grants to one port while the other requests (>=1)
// PORTS
//  Clk         in   1  clock, all state on posedge
//  Reset_n     in   1  asynchronous, active-low reset
//  Req0/Req1   in   1  access request, held until granted
//  WrEn0/WrEn1 in   1  1=write, 0=read; valid with Req
//  Addr0/Addr1 in   A  access address; valid with Req
//  WData0/WData1 in W  write data; valid with Req&WrEn
//  Gnt0/Gnt1   out  1  combinational grant; access is performed this cycle
//  RData0/RData1 out W registered read data
//  RValid0/RValid1 out 1 one-cycle pulse: RDataN valid
//  MemWriteEn  out  1  to data memory WriteEn
//  MemAddress  out  A  to data memory Address
//  MemDataIn   out  W  to data memory DataIn
//  MemDataOut  in   W  from data memory DataOut (combinational)
// BEHAVIOUR
//  State: FSM {IDLE, OWN0, OWN1} (port granted last cycle), Last (1 bit, last
//   port granted), BurstCnt (consecutive grants to current owner, sat. MAX_BURST).
//  Reset (async): IDLE, Last=1, BurstCnt=0, RValid*=0, RData*=0. While Reset_n=0:
//   Gnt*=0, MemWriteEn=0, MemAddress=0, MemDataIn=0.
//  Grant decision (combinational, exactly one or zero Gnt high):
//   - no Req: no grant; MemWriteEn=0, MemAddress=0, MemDataIn=0.
//   - one Req: grant that port, regardless of BurstCnt.
//   - both Req, state OWNn and BurstCnt<MAX_BURST: grant n (sticky).
//   - both Req, state OWNn and BurstCnt==MAX_BURST: grant the other port.
//   - both Req, state IDLE: grant port != Last (P0 wins first tie after reset).
//  Mux: granted port drives MemAddress, MemDataIn; MemWriteEn = Gnt & WrEn.
//  Transitions @posedge: grant to n -> OWNn, Last=n; BurstCnt = (state==OWNn)
//   ? sat(BurstCnt+1) : 1. No grant -> IDLE, BurstCnt=0, Last held.
//  Read: grant with WrEn=0 -> next edge RDataN<=MemDataOut, RValidN=1 for one
//   cycle; latency 1. RDataN holds until next read on that port. Writes: no
//   RValid; memory updated at the grant edge; same-port read next cycle sees new data.
//  Requester rule: Req, WrEn, Addr, WData stable while Req&!Gnt; arbiter does
//   not buffer. Deasserting Req before Gnt withdraws the request (legal).
//  Back-to-back: a port may be granted every cycle; RValid pulses may be adjacent.
//  Reset mid-operation: pending RValid dropped; write in progress not issued.
// TESTING
//  1 Reset: Reset_n=0 with Req0=Req1=1,WrEn0=1 -> Gnt*=0, MemWriteEn=0, RValid*=0.
//  2 Single port: P0 write 0x5A@0x10, then read 0x10 -> Gnt0 both cycles,
//    RValid0 one cycle after read grant, RData0=0x5A; Gnt1 never high.
//  3 Contention: both Req continuously from IDLE after reset -> grants
//    P0,P0,P0,P0,P1,P1,P1,P1,P0... (MAX_BURST=4).
//  4 Idle tie-break: P1 granted once, idle cycle, both Req -> P0 granted.
//  5 Same-address race: P0 write 0x33@0x20 and P1 read 0x20 in same cycle ->
//    P0 granted first, P1 next cycle, RData1=0x33.
//  6 Async reset between read grant and RValid -> RValid0 stays 0, RData0=0.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Port 0 is the core load/store unit and port 1 is the loader/debug port.
module dm_port_arbiter #(
  parameter int W         = 8,
  parameter int A         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Req0,
  input  logic         Req1,
  input  logic         WrEn0,
  input  logic         WrEn1,
  input  logic [A-1:0] Addr0,
  input  logic [A-1:0] Addr1,
  input  logic [W-1:0] WData0,
  input  logic [W-1:0] WData1,
  output logic         Gnt0,
  output logic         Gnt1,
  output logic [W-1:0] RData0,
  output logic [W-1:0] RData1,
  output logic         RValid0,
  output logic         RValid1,
  output logic         MemWriteEn,
  output logic [A-1:0] MemAddress,
  output logic [W-1:0] MemDataIn,
  input  logic [W-1:0] MemDataOut
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t             state_r;
  logic               last_r;
  logic [CNT_W-1:0]   burst_cnt_r;
  logic               gnt0_s;
  logic               gnt1_s;
  logic               rvalid0_r;
  logic               rvalid1_r;
  logic [W-1:0]       rdata0_r;
  logic [W-1:0]       rdata1_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= BURST_MAX) begin
      sat_inc = BURST_MAX;
    end else begin
      sat_inc = cnt + CNT_ONE;
    end
  endfunction

  // Grant decision: sticky owner until the burst limit, idle ties go to the port not served last.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!Reset_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (Req0 && Req1) begin
      case (state_r)
        ST_OWN0: begin
          if (burst_cnt_r < BURST_MAX) gnt0_s = 1'b1;
          else                         gnt1_s = 1'b1;
        end
        ST_OWN1: begin
          if (burst_cnt_r < BURST_MAX) gnt1_s = 1'b1;
          else                         gnt0_s = 1'b1;
        end
        default: begin
          if (last_r) gnt0_s = 1'b1;
          else        gnt1_s = 1'b1;
        end
      endcase
    end else if (Req0) begin
      gnt0_s = 1'b1;
    end else if (Req1) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Memory-side mux: the granted port owns the memory for this cycle.
  always_comb begin
    MemWriteEn = 1'b0;
    MemAddress = '0;
    MemDataIn  = '0;
    if (gnt0_s) begin
      MemWriteEn = WrEn0;
      MemAddress = Addr0;
      MemDataIn  = WData0;
    end else if (gnt1_s) begin
      MemWriteEn = WrEn1;
      MemAddress = Addr1;
      MemDataIn  = WData1;
    end else begin
      MemWriteEn = 1'b0;
      MemAddress = '0;
      MemDataIn  = '0;
    end
  end

  // Ownership, last-served port and burst counter update.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= ST_IDLE;
      last_r      <= 1'b1;
      burst_cnt_r <= '0;
    end else if (gnt0_s) begin
      state_r     <= ST_OWN0;
      last_r      <= 1'b0;
      burst_cnt_r <= (state_r == ST_OWN0) ? sat_inc(burst_cnt_r) : CNT_ONE;
    end else if (gnt1_s) begin
      state_r     <= ST_OWN1;
      last_r      <= 1'b1;
      burst_cnt_r <= (state_r == ST_OWN1) ? sat_inc(burst_cnt_r) : CNT_ONE;
    end else begin
      state_r     <= ST_IDLE;
      burst_cnt_r <= '0;
    end
  end

  // Read return: capture memory data one edge after a read grant; data holds until the next read.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= '0;
      rdata1_r  <= '0;
    end else begin
      rvalid0_r <= gnt0_s && !WrEn0;
      rvalid1_r <= gnt1_s && !WrEn1;
      if (gnt0_s && !WrEn0) rdata0_r <= MemDataOut;
      else                  rdata0_r <= rdata0_r;
      if (gnt1_s && !WrEn1) rdata1_r <= MemDataOut;
      else                  rdata1_r <= rdata1_r;
    end
  end

  assign Gnt0    = gnt0_s;
  assign Gnt1    = gnt1_s;
  assign RValid0 = rvalid0_r;
  assign RValid1 = rvalid1_r;
  assign RData0  = rdata0_r;
  assign RData1  = rdata1_r;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural 256x8 data memory.
module tb_dm_port_arbiter;
  logic       Clk, Reset_n;
  logic       Req0, Req1, WrEn0, WrEn1;
  logic [7:0] Addr0, Addr1, WData0, WData1;
  logic       Gnt0, Gnt1, RValid0, RValid1, MemWriteEn;
  logic [7:0] RData0, RData1, MemAddress, MemDataIn, MemDataOut;
  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;

  dm_port_arbiter #(.W(8), .A(8), .MAX_BURST(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req0(Req0), .Req1(Req1), .WrEn0(WrEn0), .WrEn1(WrEn1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .RData0(RData0), .RData1(RData1),
    .RValid0(RValid0), .RValid1(RValid1), .MemWriteEn(MemWriteEn),
    .MemAddress(MemAddress), .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
  );

  assign MemDataOut = mem[MemAddress];
  always @(posedge Clk) if (MemWriteEn) mem[MemAddress] <= MemDataIn;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic clear_inputs();
    Req0 = 1'b0; Req1 = 1'b0; WrEn0 = 1'b0; WrEn1 = 1'b0;
    Addr0 = 8'h00; Addr1 = 8'h00; WData0 = 8'h00; WData1 = 8'h00;
  endtask

  task automatic next_cycle();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    clear_inputs();
    next_cycle();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    Req0 = 1'b1; Req1 = 1'b1; WrEn0 = 1'b1; Addr0 = 8'h44; WData0 = 8'h99;
    WrEn1 = 1'b0; Addr1 = 8'h55; WData1 = 8'h00;
    next_cycle(); next_cycle();
    checks++; if (Gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0 got %b exp 0", Gnt0); end
    checks++; if (Gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1 got %b exp 0", Gnt1); end
    checks++; if (MemWriteEn !== 1'b0) begin errors++; $display("FAIL reset_wren got %b exp 0", MemWriteEn); end
    checks++; if (MemAddress !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", MemAddress); end
    checks++; if (MemDataIn !== 8'h00) begin errors++; $display("FAIL reset_din got %h exp 00", MemDataIn); end
    checks++; if ({RValid0, RValid1} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", {RValid0, RValid1}); end
    checks++; if ({RData0, RData1} !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h exp 0000", {RData0, RData1}); end
    clear_inputs();
    Reset_n = 1'b1;
  endtask

  task automatic test_single_port();
    Req0 = 1'b1; WrEn0 = 1'b1; Addr0 = 8'h10; WData0 = 8'h5A;
    #1;
    checks++; if ({Gnt0, Gnt1} !== 2'b10) begin errors++; $display("FAIL sp_wr_gnt got %b exp 10", {Gnt0, Gnt1}); end
    checks++; if ({MemWriteEn, MemAddress, MemDataIn} !== {1'b1, 8'h10, 8'h5A}) begin
      errors++; $display("FAIL sp_wr_mem got %b/%h/%h exp 1/10/5a", MemWriteEn, MemAddress, MemDataIn); end
    next_cycle();
    WrEn0 = 1'b0; WData0 = 8'h00;
    checks++; if (RValid0 !== 1'b0) begin errors++; $display("FAIL sp_wr_norvalid got %b exp 0", RValid0); end
    #1;
    checks++; if ({Gnt0, Gnt1, MemWriteEn} !== 3'b100) begin errors++; $display("FAIL sp_rd_gnt got %b exp 100", {Gnt0, Gnt1, MemWriteEn}); end
    next_cycle();
    Req0 = 1'b0;
    checks++; if ({RValid0, RData0} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL sp_rd_data got %b/%h exp 1/5a", RValid0, RData0); end
    checks++; if (RValid1 !== 1'b0) begin errors++; $display("FAIL sp_rvalid1 got %b exp 0", RValid1); end
    next_cycle();
    checks++; if ({RValid0, RData0, Gnt1} !== {1'b0, 8'h5A, 1'b0}) begin
      errors++; $display("FAIL sp_rd_pulse got %b/%h/%b exp 0/5a/0", RValid0, RData0, Gnt1); end
  endtask

  task automatic test_contention();
    logic [9:0] exp_p1;
    exp_p1 = 10'b00_1111_0000;
    do_reset();
    Req0 = 1'b1; Req1 = 1'b1; Addr0 = 8'h01; Addr1 = 8'h02;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if ({Gnt0, Gnt1} !== {~exp_p1[i], exp_p1[i]}) begin
        errors++; $display("FAIL contention_%0d got %b exp %b", i, {Gnt0, Gnt1}, {~exp_p1[i], exp_p1[i]});
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_idle_tiebreak();
    do_reset();
    Req1 = 1'b1;
    #1;
    checks++; if ({Gnt0, Gnt1} !== 2'b01) begin errors++; $display("FAIL tie_p1 got %b exp 01", {Gnt0, Gnt1}); end
    next_cycle();
    Req1 = 1'b0;
    #1;
    checks++; if ({Gnt0, Gnt1} !== 2'b00) begin errors++; $display("FAIL tie_idle got %b exp 00", {Gnt0, Gnt1}); end
    next_cycle();
    Req0 = 1'b1; Req1 = 1'b1;
    #1;
    checks++; if ({Gnt0, Gnt1} !== 2'b10) begin errors++; $display("FAIL tie_p0 got %b exp 10", {Gnt0, Gnt1}); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_same_addr_race();
    do_reset();
    Req0 = 1'b1; WrEn0 = 1'b1; Addr0 = 8'h20; WData0 = 8'h33;
    Req1 = 1'b1; WrEn1 = 1'b0; Addr1 = 8'h20;
    #1;
    checks++; if ({Gnt0, Gnt1} !== 2'b10) begin errors++; $display("FAIL race_first got %b exp 10", {Gnt0, Gnt1}); end
    next_cycle();
    Req0 = 1'b0; WrEn0 = 1'b0;
    #1;
    checks++; if ({Gnt0, Gnt1, MemAddress} !== {2'b01, 8'h20}) begin
      errors++; $display("FAIL race_second got %b/%h exp 01/20", {Gnt0, Gnt1}, MemAddress); end
    next_cycle();
    Req1 = 1'b0;
    checks++; if ({RValid1, RData1, RValid0} !== {1'b1, 8'h33, 1'b0}) begin
      errors++; $display("FAIL race_rdata got %b/%h/%b exp 1/33/0", RValid1, RData1, RValid0); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    Req0 = 1'b1; WrEn0 = 1'b0; Addr0 = 8'h10;
    next_cycle();
    Addr0 = 8'h20;
    checks++; if ({RValid0, RData0} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL b2b_first got %b/%h exp 1/5a", RValid0, RData0); end
    next_cycle();
    Req0 = 1'b0;
    checks++; if ({RValid0, RData0} !== {1'b1, 8'h33}) begin errors++; $display("FAIL b2b_second got %b/%h exp 1/33", RValid0, RData0); end
    next_cycle();
    checks++; if ({RValid0, RData0} !== {1'b0, 8'h33}) begin errors++; $display("FAIL b2b_hold got %b/%h exp 0/33", RValid0, RData0); end
  endtask

  task automatic test_reset_mid();
    Req0 = 1'b1; WrEn0 = 1'b0; Addr0 = 8'h10;
    #1;
    checks++; if (Gnt0 !== 1'b1) begin errors++; $display("FAIL mid_gnt got %b exp 1", Gnt0); end
    #2;
    Reset_n = 1'b0;
    clear_inputs();
    #1;
    checks++; if ({RValid0, RData0} !== {1'b0, 8'h00}) begin errors++; $display("FAIL mid_async got %b/%h exp 0/00", RValid0, RData0); end
    next_cycle();
    checks++; if ({RValid0, RData0} !== {1'b0, 8'h00}) begin errors++; $display("FAIL mid_after got %b/%h exp 0/00", RValid0, RData0); end
    Reset_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    Reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_port();
    test_contention();
    test_idle_tiebreak();
    test_same_addr_race();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
